// File: rtl/spi_master_byte.sv
// spi_master_byte: byte-oriented SPI master, mode 0, MSB first, 8-bit frames,
// active-low slave select framed by the host's last-byte flag.
//
// Ports:
//   clk, rst          system clock, synchronous active-high reset
//   tx_valid/tx_ready host byte handshake; tx_data/tx_last sampled on handshake
//   tx_last           1 = release SSEL after this byte
//   rx_valid          one-cycle pulse, rx_data holds the byte just received
//   rx_data           last received byte, held until the next rx_valid
//   busy              1 whenever the engine is not idle
//   SCK, MOSI, SSEL   SPI outputs (SCK idles low, SSEL active low)
//   MISO              serial data from the slave
module spi_master_byte #(
  parameter int unsigned CLK_DIV  = 4,
  parameter int unsigned CS_SETUP = 4,
  parameter int unsigned CS_IDLE  = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       tx_valid,
  output logic       tx_ready,
  input  logic [7:0] tx_data,
  input  logic       tx_last,
  output logic       rx_valid,
  output logic [7:0] rx_data,
  output logic       busy,
  output logic       SCK,
  output logic       MOSI,
  output logic       SSEL,
  input  logic       MISO
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SETUP,
    S_SHIFT,
    S_NEXT,
    S_HOLD,
    S_GAP
  } state_t;

  localparam logic [7:0] DIV_M1   = 8'(CLK_DIV - 1);
  localparam logic [7:0] SETUP_M1 = 8'(CS_SETUP - 1);
  localparam logic [7:0] IDLE_M1  = 8'(CS_IDLE - 1);

  state_t     r_state;
  logic [7:0] r_cnt;
  logic [2:0] r_bit;
  logic [6:0] r_tx_sr;   // remaining bits after the one already on MOSI
  logic [7:0] r_rx_sr;
  logic       r_last;
  logic       r_miso;
  logic       r_tx_ready;
  logic       r_rx_valid;
  logic [7:0] r_rx_data;
  logic       r_busy;
  logic       r_sck;
  logic       r_mosi;
  logic       r_ssel;

  logic       w_hs;
  logic       w_div_end;

  assign w_hs      = r_tx_ready & tx_valid;
  assign w_div_end = (r_cnt == DIV_M1);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_cnt      <= '0;
      r_bit      <= '0;
      r_tx_sr    <= '0;
      r_rx_sr    <= '0;
      r_last     <= 1'b0;
      r_miso     <= 1'b0;
      r_tx_ready <= 1'b0;
      r_rx_valid <= 1'b0;
      r_rx_data  <= '0;
      r_busy     <= 1'b0;
      r_sck      <= 1'b0;
      r_mosi     <= 1'b0;
      r_ssel     <= 1'b1;
    end else begin
      r_rx_valid <= 1'b0;
      r_miso     <= MISO;
      case (r_state)
        S_IDLE: begin
          r_ssel <= 1'b1;
          r_sck  <= 1'b0;
          if (w_hs) begin
            r_tx_sr    <= tx_data[6:0];
            r_last     <= tx_last;
            r_mosi     <= tx_data[7];
            r_ssel     <= 1'b0;
            r_tx_ready <= 1'b0;
            r_busy     <= 1'b1;
            r_cnt      <= '0;
            r_state    <= S_SETUP;
          end else begin
            // ready comes up one cycle after reset release
            r_tx_ready <= 1'b1;
          end
        end

        S_SETUP: begin
          if (r_cnt == SETUP_M1) begin
            r_cnt   <= '0;
            r_bit   <= '0;
            r_state <= S_SHIFT;
          end else begin
            r_cnt <= r_cnt + 8'd1;
          end
        end

        S_SHIFT: begin
          if (w_div_end) begin
            r_cnt <= '0;
            if (!r_sck) begin
              r_sck   <= 1'b1;
              r_rx_sr <= {r_rx_sr[6:0], r_miso};
            end else begin
              r_sck <= 1'b0;
              if (r_bit == 3'd7) begin
                r_bit      <= '0;
                r_rx_data  <= r_rx_sr;
                r_rx_valid <= 1'b1;
                r_state    <= r_last ? S_HOLD : S_NEXT;
              end else begin
                r_bit   <= r_bit + 3'd1;
                r_mosi  <= r_tx_sr[6];
                r_tx_sr <= {r_tx_sr[5:0], 1'b0};
              end
            end
          end else begin
            r_cnt <= r_cnt + 8'd1;
          end
        end

        S_NEXT: begin
          // tx_ready rises on the first NEXT edge so it never overlaps rx_valid
          if (w_hs) begin
            r_tx_sr    <= tx_data[6:0];
            r_last     <= tx_last;
            r_mosi     <= tx_data[7];
            r_tx_ready <= 1'b0;
            r_cnt      <= '0;
            r_bit      <= '0;
            r_state    <= S_SHIFT;
          end else begin
            r_tx_ready <= 1'b1;
          end
        end

        S_HOLD: begin
          if (w_div_end) begin
            r_ssel  <= 1'b1;
            r_mosi  <= 1'b0;
            r_cnt   <= '0;
            r_state <= S_GAP;
          end else begin
            r_cnt <= r_cnt + 8'd1;
          end
        end

        S_GAP: begin
          if (r_cnt == IDLE_M1) begin
            r_cnt      <= '0;
            r_busy     <= 1'b0;
            r_tx_ready <= 1'b1;
            r_state    <= S_IDLE;
          end else begin
            r_cnt <= r_cnt + 8'd1;
          end
        end

        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign tx_ready = r_tx_ready;
  assign rx_valid = r_rx_valid;
  assign rx_data  = r_rx_data;
  assign busy     = r_busy;
  assign SCK      = r_sck;
  assign MOSI     = r_mosi;
  assign SSEL     = r_ssel;

endmodule
